// File: rtl/bcd_stopwatch_core_if.sv
// Signal bundle between the stopwatch core and its surrounding logic.
// The master side drives enables/controls; the slave side (the core) drives the display and lap digits.
interface bcd_stopwatch_core_if;
  logic       tick_1hz;
  logic       tick_adj;
  logic       pause_pulse;
  logic       pause_level;
  logic       adj_mode;
  logic       sel;
  logic       mode_down;
  logic       lap_pulse;
  logic [3:0] mt;
  logic [3:0] mo;
  logic [3:0] st;
  logic [3:0] so;
  logic       running;
  logic       adjusting;
  logic       expired;
  logic       lap_valid;
  logic [3:0] lap_mt;
  logic [3:0] lap_mo;
  logic [3:0] lap_st;
  logic [3:0] lap_so;

  modport master (
    output tick_1hz, tick_adj, pause_pulse, pause_level, adj_mode, sel, mode_down, lap_pulse,
    input  mt, mo, st, so, running, adjusting, expired,
    input  lap_valid, lap_mt, lap_mo, lap_st, lap_so
  );

  modport slave (
    input  tick_1hz, tick_adj, pause_pulse, pause_level, adj_mode, sel, mode_down, lap_pulse,
    output mt, mo, st, so, running, adjusting, expired,
    output lap_valid, lap_mt, lap_mo, lap_st, lap_so
  );
endinterface

// File: rtl/bcd_stopwatch_core.sv
// BCD mm:ss stopwatch / countdown timer with run, pause, adjust and expiry states.
// Optional lap capture is built only when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch_core #(
  parameter int unsigned MIN_MAX    = 59,
  parameter int unsigned PRESET_MIN = 0
) (
  input  logic                  clk_100mhz,
  input  logic                  rst,
  bcd_stopwatch_core_if.slave   bus
);

  typedef enum logic [1:0] {PAUSED, RUN, ADJUST, EXPIRED} state_t;

  localparam logic [7:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
  localparam logic [7:0] PRESET_BCD  = {4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10)};
  localparam logic [7:0] SEC_MAX_BCD = 8'h59;

  state_t     r_state;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_expired;
  logic       r_running;
  logic       r_adjusting;

  state_t     w_next;
  logic [7:0] w_min;
  logic [7:0] w_sec;
  logic       w_expired;
  logic       w_adj_evt;

  // Two-digit BCD increment that wraps to 00 after lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD decrement; callers never pass 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_adj_evt = bus.pause_pulse | (bus.tick_adj & bus.pause_level);

  always_comb begin
    w_next    = r_state;
    w_min     = r_min;
    w_sec     = r_sec;
    w_expired = 1'b0;
    if (bus.adj_mode) begin
      // A pause press only increments once already adjusting; on entry it is swallowed.
      w_next = ADJUST;
      if (r_state == ADJUST && w_adj_evt) begin
        if (bus.sel)
          w_sec = bcd_inc(r_sec, SEC_MAX_BCD);
        else
          w_min = bcd_inc(r_min, MIN_MAX_BCD);
      end
    end else begin
      case (r_state)
        PAUSED: begin
          if (bus.pause_pulse)
            w_next = RUN;
        end
        RUN: begin
          if (bus.tick_1hz) begin
            if (!bus.mode_down) begin
              w_sec = bcd_inc(r_sec, SEC_MAX_BCD);
              if (r_sec == SEC_MAX_BCD)
                w_min = bcd_inc(r_min, MIN_MAX_BCD);
            end else if (r_min == 8'h00 && r_sec == 8'h00) begin
              w_expired = 1'b1;
              w_next    = EXPIRED;
            end else if (r_sec == 8'h00) begin
              w_sec = SEC_MAX_BCD;
              w_min = bcd_dec(r_min);
            end else begin
              w_sec = bcd_dec(r_sec);
            end
          end
          // The count for this cycle still lands before pausing.
          if (bus.pause_pulse)
            w_next = PAUSED;
        end
        ADJUST: w_next = PAUSED;
        EXPIRED: begin
          if (bus.pause_pulse)
            w_next = PAUSED;
        end
        default: w_next = PAUSED;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_state     <= PAUSED;
      r_min       <= PRESET_BCD;
      r_sec       <= 8'h00;
      r_expired   <= 1'b0;
      r_running   <= 1'b0;
      r_adjusting <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_min       <= w_min;
      r_sec       <= w_sec;
      r_expired   <= w_expired;
      r_running   <= (w_next == RUN);
      r_adjusting <= (w_next == ADJUST);
    end
  end

  assign bus.mt        = r_min[7:4];
  assign bus.mo        = r_min[3:0];
  assign bus.st        = r_sec[7:4];
  assign bus.so        = r_sec[3:0];
  assign bus.running   = r_running;
  assign bus.adjusting = r_adjusting;
  assign bus.expired   = r_expired;

`ifdef STOPWATCH_LAP_EN
  logic        r_lap_valid;
  logic [15:0] r_lap;

  // Captures the pre-tick value because r_min/r_sec have not yet taken this cycle's count.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_lap_valid <= 1'b0;
      r_lap       <= '0;
    end else if (r_state == RUN && bus.lap_pulse) begin
      r_lap_valid <= 1'b1;
      r_lap       <= {r_min, r_sec};
    end
  end

  assign bus.lap_valid = r_lap_valid;
  assign bus.lap_mt    = r_lap[15:12];
  assign bus.lap_mo    = r_lap[11:8];
  assign bus.lap_st    = r_lap[7:4];
  assign bus.lap_so    = r_lap[3:0];
`else
  logic w_unused_lap;
  assign w_unused_lap  = bus.lap_pulse;
  assign bus.lap_valid = 1'b0;
  assign bus.lap_mt    = '0;
  assign bus.lap_mo    = '0;
  assign bus.lap_st    = '0;
  assign bus.lap_so    = '0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Bench for bcd_stopwatch_core: directed scenarios then random stimulus, all checked
// against a time-in-seconds reference model.
module tb_bcd_stopwatch_core;
  localparam int MM = 59;
  localparam int PM = 0;
  localparam int S_P = 0, S_R = 1, S_A = 2, S_E = 3;

  logic clk = 1'b0;
  logic rst;
  bcd_stopwatch_core_if bus ();

  bcd_stopwatch_core #(.MIN_MAX(MM), .PRESET_MIN(PM)) dut (
    .clk_100mhz (clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int m_state, m_t, m_lapt, m_mins, m_secs;
  bit m_exp, m_lapv;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time held as total seconds, state as a plain number.
  always @(posedge clk) begin
    if (rst) begin
      m_state = S_P;
      m_t     = PM * 60;
      m_exp   = 1'b0;
      m_lapv  = 1'b0;
      m_lapt  = 0;
    end else begin
      m_exp = 1'b0;
`ifdef STOPWATCH_LAP_EN
      if (m_state == S_R && bus.lap_pulse) begin
        m_lapv = 1'b1;
        m_lapt = m_t;
      end
`endif
      if (bus.adj_mode) begin
        if (m_state == S_A && (bus.pause_pulse || (bus.tick_adj && bus.pause_level))) begin
          m_mins = m_t / 60;
          m_secs = m_t % 60;
          if (bus.sel) m_secs = (m_secs + 1) % 60;
          else         m_mins = (m_mins + 1) % (MM + 1);
          m_t = m_mins * 60 + m_secs;
        end
        m_state = S_A;
      end else begin
        case (m_state)
          S_P: if (bus.pause_pulse) m_state = S_R;
          S_R: begin
            if (bus.tick_1hz) begin
              if (!bus.mode_down) m_t = (m_t + 1) % ((MM + 1) * 60);
              else if (m_t == 0) begin
                m_exp   = 1'b1;
                m_state = S_E;
              end else m_t = m_t - 1;
            end
            if (bus.pause_pulse) m_state = S_P;
          end
          S_A: m_state = S_P;
          default: if (bus.pause_pulse) m_state = S_P;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mt", int'(bus.mt), (m_t / 60) / 10);
      chk("mo", int'(bus.mo), (m_t / 60) % 10);
      chk("st", int'(bus.st), (m_t % 60) / 10);
      chk("so", int'(bus.so), (m_t % 60) % 10);
      chk("running", int'(bus.running), int'(m_state == S_R));
      chk("adjusting", int'(bus.adjusting), int'(m_state == S_A));
      chk("expired", int'(bus.expired), int'(m_exp));
      chk("lap_valid", int'(bus.lap_valid), int'(m_lapv));
      chk("lap_mt", int'(bus.lap_mt), (m_lapt / 60) / 10);
      chk("lap_mo", int'(bus.lap_mo), (m_lapt / 60) % 10);
      chk("lap_st", int'(bus.lap_st), (m_lapt % 60) / 10);
      chk("lap_so", int'(bus.lap_so), (m_lapt % 60) % 10);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
    rst             = 1'b0;
    bus.tick_1hz    = 1'b0;
    bus.tick_adj    = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.lap_pulse   = 1'b0;
  endtask

  task automatic press(input int n);
    repeat (n) begin
      bus.pause_pulse = 1'b1;
      cycle();
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.tick_1hz = 1'b1;
      cycle();
    end
  endtask

  task automatic check_time(input string name, input int mm, input int ss);
    chk({name, "_mt"}, int'(bus.mt), mm / 10);
    chk({name, "_mo"}, int'(bus.mo), mm % 10);
    chk({name, "_st"}, int'(bus.st), ss / 10);
    chk({name, "_so"}, int'(bus.so), ss % 10);
    chk({name, "_model"}, m_t, mm * 60 + ss);
  endtask

  initial begin
    rst             = 1'b1;
    bus.tick_1hz    = 1'b0;
    bus.tick_adj    = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.pause_level = 1'b0;
    bus.adj_mode    = 1'b0;
    bus.sel         = 1'b0;
    bus.mode_down   = 1'b0;
    bus.lap_pulse   = 1'b0;
    cycle();
    chk_en = 1'b1;
    check_time("reset", PM, 0);
    chk("reset_running", int'(bus.running), 0);

    // Start and count 61 seconds
    press(1);
    ticks(61);
    check_time("up61", 1, 1);
    chk("up61_running", int'(bus.running), 1);

    // Adjust to 03:27, run, then reset while ticking and pressing
    bus.adj_mode = 1'b1; cycle();
    bus.sel = 1'b0; press(2);
    bus.sel = 1'b1; press(26);
    bus.adj_mode = 1'b0; cycle();
    press(1);
    check_time("pre_rst", 3, 27);
    chk("pre_rst_running", int'(bus.running), 1);
    rst = 1'b1; bus.tick_1hz = 1'b1; bus.pause_pulse = 1'b1; cycle();
    check_time("mid_rst", PM, 0);
    chk("mid_rst_running", int'(bus.running), 0);
    chk("mid_rst_expired", int'(bus.expired), 0);

    // 59:59 wraps to 00:00
    bus.adj_mode = 1'b1; cycle();
    bus.sel = 1'b0; press(59);
    bus.sel = 1'b1; press(59);
    check_time("adj_max", 59, 59);
    bus.adj_mode = 1'b0; cycle();
    press(1);
    ticks(1);
    check_time("wrap", 0, 0);

    // Countdown from 00:02 to expiry
    bus.adj_mode = 1'b1; cycle();
    bus.sel = 1'b1; press(2);
    bus.adj_mode = 1'b0; cycle();
    press(1);
    bus.mode_down = 1'b1;
    ticks(1); check_time("down1", 0, 1);
    ticks(1); check_time("down0", 0, 0);
    ticks(1); check_time("expire", 0, 0);
    chk("expire_pulse", int'(bus.expired), 1);
    cycle();
    chk("expire_once", int'(bus.expired), 0);
    ticks(1); check_time("expired_hold", 0, 0);
    chk("expired_hold_pulse", int'(bus.expired), 0);

    // Seconds adjust wraps without carry; combined events count once
    bus.adj_mode = 1'b1; cycle();
    bus.sel = 1'b1; press(58);
    check_time("adj58", 0, 58);
    bus.pause_level = 1'b1;
    bus.tick_adj = 1'b1; cycle();
    bus.tick_adj = 1'b1; cycle();
    bus.tick_adj = 1'b1; bus.pause_pulse = 1'b1; cycle();
    check_time("adj_wrap", 0, 1);
    bus.pause_level = 1'b0;
    bus.sel = 1'b0; press(1);
    check_time("adj_min", 1, 1);

    // Lap capture together with a tick
    bus.adj_mode = 1'b0;
    rst = 1'b1; cycle();
    press(1);
    bus.mode_down = 1'b0;
    ticks(7);
    check_time("pre_lap", 0, 7);
    bus.lap_pulse = 1'b1; bus.tick_1hz = 1'b1; cycle();
    check_time("lap_tick", 0, 8);
`ifdef STOPWATCH_LAP_EN
    chk("lap_valid_lit", int'(bus.lap_valid), 1);
    chk("lap_so_lit", int'(bus.lap_so), 7);
`else
    chk("lap_valid_lit", int'(bus.lap_valid), 0);
    chk("lap_so_lit", int'(bus.lap_so), 0);
`endif

    // Random stimulus
    for (int i = 0; i < 6000; i++) begin
      bus.tick_1hz    = ($urandom_range(2) == 0);
      bus.pause_pulse = ($urandom_range(11) == 0);
      bus.tick_adj    = ($urandom_range(3) == 0);
      bus.lap_pulse   = ($urandom_range(15) == 0);
      if ($urandom_range(31) == 0) bus.pause_level = ~bus.pause_level;
      if ($urandom_range(47) == 0) bus.sel = ~bus.sel;
      if ($urandom_range(79) == 0) bus.mode_down = ~bus.mode_down;
      if ($urandom_range(99) == 0) bus.adj_mode = ~bus.adj_mode;
      rst = ($urandom_range(799) == 0);
      cycle();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_stopwatch_core.md
BCD_STOPWATCH_CORE -- requirements
Module: bcd_stopwatch_core

Interface
REQ-001 SHALL have parameter MIN_MAX, default 59: maximum minutes value, legal range 1..99.
REQ-002 SHALL have parameter PRESET_MIN, default 0: minutes loaded at reset, legal range 0..MIN_MAX.
REQ-003 SHALL have port clk_100mhz  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port tick_1hz  in  1  one-cycle count enable.
REQ-006 SHALL have port tick_adj  in  1  one-cycle adjust-stream enable.
REQ-007 SHALL have port pause_pulse  in  1  one-cycle debounced pause press.
REQ-008 SHALL have port pause_level  in  1  debounced pause held level.
REQ-009 SHALL have ports adj_mode, sel, mode_down  in  1 each: adjust enable; field select (1 = seconds, 0 = minutes); count direction (1 = down).
REQ-010 SHALL have port lap_pulse  in  1  one-cycle lap capture request.
REQ-011 SHALL have ports mt, mo, st, so  out  4 each: BCD minutes tens/ones and seconds tens/ones.
REQ-012 SHALL have ports running, adjusting, expired  out  1 each: in RUN; in ADJUST; one-cycle expiry pulse.
REQ-013 SHALL have ports lap_valid  out  1 and lap_mt, lap_mo, lap_st, lap_so  out  4 each: captured lap time.

Function
REQ-014 SHALL implement states PAUSED, RUN, ADJUST and EXPIRED; all outputs registered.
REQ-015 PAUSED: pause_pulse -> RUN; adj_mode=1 -> ADJUST.
REQ-016 RUN: pause_pulse -> PAUSED; adj_mode=1 -> ADJUST.
REQ-017 ADJUST: entered from any state when adj_mode=1; adj_mode=0 -> PAUSED; the time value is kept.
REQ-018 EXPIRED: pause_pulse -> PAUSED; adj_mode=1 -> ADJUST; the display holds 00:00.
REQ-019 Up count (RUN, tick_1hz, mode_down=0): so 9->0 carries into st; st 5->0 carries into mo; mo 9->0 carries into mt; MIN_MAX:59 wraps to 00:00.
REQ-020 Down count (RUN, tick_1hz, mode_down=1): borrows mirror the up-count carries; a tick at 00:00 -> EXPIRED, expired=1 for exactly one cycle, digits stay 00:00.
REQ-021 Count latency: digits update on the clock edge at which tick_1hz=1 is sampled and are visible the following cycle.
REQ-022 Counting SHALL occur only in RUN; tick_1hz is ignored in every other state.
REQ-023 mode_down is sampled at every tick, so a change applies from the next tick.
REQ-024 ADJUST, sel=1: each qualifying event increments seconds 00..59, wraps to 00, no carry into minutes.
REQ-025 ADJUST, sel=0: each qualifying event increments minutes 00..MIN_MAX, wraps to 00; seconds are unchanged.
REQ-026 ADJUST qualifying event: pause_pulse, or tick_adj while pause_level=1; when both occur in one cycle, exactly one increment.
REQ-027 RUN with tick_1hz and pause_pulse in the same cycle: apply the count, then enter PAUSED.
REQ-028 PAUSED with tick_1hz and pause_pulse in the same cycle: enter RUN; no count that cycle.
REQ-029 adj_mode=1 together with pause_pulse: ADJUST takes priority; the pulse is consumed as a qualifying increment only if already in ADJUST.
REQ-030 running=1 iff in RUN; adjusting=1 iff in ADJUST.
REQ-031 Digits SHALL never hold non-BCD values, so st stays 0..5 and minutes stay 0..MIN_MAX.

Reset
REQ-032 rst=1 SHALL force PAUSED; digits load PRESET_MIN:00; running, adjusting, expired and lap_valid go to 0; lap digits go to 0.
REQ-033 rst SHALL override every other input in the same cycle, including mid-adjust and mid-count.
REQ-034 The first state change after reset SHALL occur no earlier than the cycle after rst deasserts.

Configuration
REQ-035 Macro STOPWATCH_LAP_EN defined: lap_pulse in RUN captures the current digits into the lap_* outputs on the next edge and sets lap_valid=1, which holds until reset.
REQ-036 With STOPWATCH_LAP_EN defined: a later lap_pulse overwrites the capture; lap_pulse outside RUN is ignored; lap_pulse together with tick_1hz captures the pre-tick value.
REQ-037 STOPWATCH_LAP_EN undefined: lap_pulse is ignored, lap_valid and lap_* are tied to 0, and no lap registers exist.

Verification
REQ-038 Reset with PRESET_MIN=0, then pause_pulse, then 61 tick_1hz -> digits 01:01, running=1.
REQ-039 MIN_MAX=59, adjust to 59:59, exit, run one up tick -> 00:00.
REQ-040 Preset 00:02, mode_down=1, run 3 ticks -> 00:01, then 00:00, then expired=1 for one cycle and state EXPIRED; a 4th tick leaves 00:00 with expired=0.
REQ-041 ADJUST sel=1 from 00:58, pause_level=1 with 3 tick_adj -> 00:01 (minutes unchanged); then sel=0 plus pause_pulse -> 01:01.
REQ-042 With STOPWATCH_LAP_EN: run to 00:07, lap_pulse together with tick_1hz -> lap 00:07, digits 00:08, lap_valid=1; without the macro, lap_valid stays 0.
REQ-043 Assert rst during RUN at 03:27 -> next cycle PRESET_MIN:00, PAUSED, all flags 0.
